// File: rtl/jt51_sh_defs.sv
// Shared definitions for the jt51_sh_ring delay line: FSM state encoding
// and the output-source select used to build drop from registered values.
package jt51_sh_defs;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SRC_RST = 2'd0,
        SRC_BYP = 2'd1,
        SRC_RAM = 2'd2
    } src_t;

endpackage

// File: rtl/jt51_sh_ram.sv
// Simple dual-port RAM, one synchronous write and one synchronous read port.
// A read colliding with a write to the same address returns the old word.
module jt51_sh_ram #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its read register carry no reset so the tools can map
    // them onto block RAM; the clear sweep in the ring initialises the contents.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/jt51_sh_ring.sv
// RAM-backed delay line with run-time length 1..DEPTH and a hardware clear
// sweep after reset or flush.
module jt51_sh_ring
    import jt51_sh_defs::*;
#(
    parameter int   WIDTH  = 5,
    parameter int   DEPTH  = 32,
    parameter int   AW     = $clog2(DEPTH),
    parameter logic RSTVAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             flush,
    input  logic [AW:0]      len,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] drop,
    output logic             ready
);

    localparam logic [WIDTH-1:0] RST_WORD = {WIDTH{RSTVAL}};
    localparam logic [AW:0]      DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0]      ONE_W    = (AW+1)'(1);
    localparam logic [AW-1:0]    LAST     = AW'(DEPTH-1);

    state_t           state, state_nxt;
    src_t             src;
    logic [AW-1:0]    cp, wp, raddr;
    logic [AW:0]      eff_len, raddr_ext;
    logic [WIDTH-1:0] byp, ram_q;
    logic             step, ram_we;

    assign step  = !rst && state == ST_RUN && cen && !flush;
    assign ready = state == ST_RUN;

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        eff_len = len;
        if (len == '0)          eff_len = ONE_W;
        else if (len > DEPTH_W) eff_len = DEPTH_W;
    end

    // wp+1-L made non-negative by adding DEPTH; the sum may wrap AW+1 bits
    // transiently but the final value is below 2*DEPTH.
    always_comb begin
        raddr_ext = {1'b0, wp} + ONE_W + DEPTH_W - eff_len;
        raddr     = (raddr_ext >= DEPTH_W) ? AW'(raddr_ext - DEPTH_W) : AW'(raddr_ext);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (!flush && cp == LAST) state_nxt = ST_RUN;
            ST_RUN:  if (flush)                state_nxt = ST_INIT;
            default:                           state_nxt = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cp  <= '0;
            wp  <= '0;
            src <= SRC_RST;
            byp <= RST_WORD;
        end else begin
            case (state)
                ST_INIT: begin
                    cp  <= (flush || cp == LAST) ? '0 : cp + 1'b1;
                    wp  <= '0;
                    src <= SRC_RST;
                end
                default: begin
                    if (flush) begin
                        cp  <= '0;
                        src <= SRC_RST;
                    end else if (cen) begin
                        wp  <= (wp == LAST) ? '0 : wp + 1'b1;
                        src <= (eff_len == ONE_W) ? SRC_BYP : SRC_RAM;
                        byp <= din;
                    end
                end
            endcase
        end
    end

    assign ram_we = !rst && (state == ST_INIT || step);

    jt51_sh_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (state == ST_INIT ? cp : wp),
        .wdata (state == ST_INIT ? RST_WORD : din),
        .re    (step),
        .raddr (raddr),
        .rdata (ram_q)
    );

    // drop is a select among registers only; din never reaches it combinationally.
    always_comb begin
        case (src)
            SRC_BYP: drop = byp;
            SRC_RAM: drop = ram_q;
            default: drop = RST_WORD;
        endcase
    end

endmodule

// File: tb/tb_jt51_sh_ring.sv
// Bench for jt51_sh_ring: DEPTH=32 and DEPTH=24 instances checked against a
// history-queue model of the delay line.
module tb_jt51_sh_ring;

    logic       clk = 1'b0;
    logic       rst32, rst24, cen, flush;
    logic [5:0] len;
    logic [4:0] din;
    logic [4:0] drop32, drop24;
    logic       ready32, ready24;

    int vectors     = 0;
    int miscompares = 0;
    int nstep       = 0;
    int sel         = 32;

    // Model: all words accepted since the last sweep, plus INIT bookkeeping.
    int         m_depth = 32;
    bit         m_run   = 1'b0;
    int         m_sc    = 0;
    logic [4:0] m_drop  = 5'd0;
    logic [4:0] hist[$];

    always #5 clk = ~clk;

    jt51_sh_ring #(.WIDTH(5), .DEPTH(32)) dut32 (
        .clk(clk), .rst(rst32), .cen(cen), .flush(flush),
        .len(len), .din(din), .drop(drop32), .ready(ready32)
    );

    jt51_sh_ring #(.WIDTH(5), .DEPTH(24)) dut24 (
        .clk(clk), .rst(rst24), .cen(cen), .flush(flush),
        .len(len), .din(din), .drop(drop24), .ready(ready24)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s (depth %0d, step %0d): observed %0h expected %0h",
                   tag, sel, nstep, obs, exp);
        end
    endtask

    function automatic int eff_len(input int l);
        if (l == 0) return 1;
        if (l > m_depth) return m_depth;
        return l;
    endfunction

    task automatic step(input logic c, input logic [4:0] d, input logic [5:0] l,
                        input logic f, input logic r);
        int idx;
        cen = c; din = d; len = l; flush = f;
        if (sel == 32) begin rst32 = r; rst24 = 1'b1; end
        else           begin rst24 = r; rst32 = 1'b1; end
        @(posedge clk);
        m_depth = sel;
        if (r || (m_run && f)) begin
            m_run = 1'b0; m_sc = 0; m_drop = 5'd0; hist.delete();
        end else if (!m_run) begin
            if (f) m_sc = 0;
            else begin
                m_sc++;
                if (m_sc == m_depth) m_run = 1'b1;
            end
        end else if (c) begin
            hist.push_back(d);
            idx    = hist.size() - eff_len(int'(l));
            m_drop = (idx >= 0) ? hist[idx] : 5'd0;
        end
        #1;
        nstep++;
        check("drop",  8'(sel == 32 ? drop32 : drop24),   8'(m_drop));
        check("ready", 8'(sel == 32 ? ready32 : ready24), 8'(m_run));
    endtask

    function automatic logic [4:0] rnd5();
        return 5'($urandom_range(31, 0));
    endfunction

    initial begin
        rst32 = 1'b1; rst24 = 1'b1; cen = 1'b0; flush = 1'b0; len = 6'd32; din = 5'd0;

        // Reset and full sweep with cen tied high and live din.
        step(1'b1, rnd5(), 6'd32, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b1, rnd5(), 6'd32, 1'b0, 1'b0);

        // Full-length delay across several write-pointer wraps.
        for (int i = 0; i < 132; i++) step(1'b1, 5'(i), 6'd32, 1'b0, 1'b0);

        // Bypass path and hold with cen low.
        step(1'b1, 5'h15, 6'd1, 1'b0, 1'b0);
        step(1'b1, 5'h0A, 6'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, rnd5(), 6'd1, 1'b0, 1'b0);

        // Length clamps.
        for (int i = 0; i < 10; i++) step(1'b1, rnd5(), 6'd0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'($urandom_range(1, 0)), rnd5(), 6'd40, 1'b0, 1'b0);

        // Length change without re-sweep.
        for (int i = 0; i < 20; i++) step(1'b1, rnd5(), 6'd8, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)  step(1'b1, rnd5(), 6'd4, 1'b0, 1'b0);

        // Flush colliding with a step, then a second flush mid-sweep.
        for (int i = 0; i < 5; i++) step(1'b1, 5'h1F, 6'd32, 1'b0, 1'b0);
        step(1'b1, 5'h1F, 6'd32, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 5'h1F, 6'd32, 1'b0, 1'b0);
        step(1'b1, 5'h1F, 6'd32, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) step(1'b1, 5'h1F, 6'd32, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, rnd5(), 6'd32, 1'b0, 1'b0);

        // Random mix of cen, len (including out-of-range) and rare flushes.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(3, 0) != 0), rnd5(), 6'($urandom_range(40, 0)),
                 1'($urandom_range(63, 0) == 0), 1'b0);

        // Reset landing at cp=10 of a sweep restarts it.
        step(1'b1, rnd5(), 6'd32, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, rnd5(), 6'd32, 1'b0, 1'b0);
        step(1'b1, rnd5(), 6'd32, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b1, rnd5(), 6'd32, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, rnd5(), 6'd32, 1'b0, 1'b0);

        // Non-power-of-two depth.
        sel = 24;
        step(1'b1, rnd5(), 6'd24, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++)  step(1'b1, rnd5(), 6'd24, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 5'(i), 6'd24, 1'b0, 1'b0);
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(3, 0) != 0), rnd5(), 6'($urandom_range(30, 0)),
                 1'($urandom_range(63, 0) == 0), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
